// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Final pipeline stage between MEM and the register file. Accepts one retiring
// instruction per cycle over a valid/ready handshake, selects the result
// source, and drives a registered register-file write port. Loads park the
// unit in WAIT_RSP until the data-memory response arrives. The returned word
// is then byte-aligned and sign/zero-extended. Misaligned or illegal loads
// raise a one-cycle trap instead of retiring.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_valid / o_ready            MEM-stage handshake (o_ready is state-only)
//   i_reg_write, i_mem_read      instruction writes rd / instruction is a load
//   i_wb_sel                     0 alu, 1 mem, 2 pc_plus4, 3 imm
//   i_rd_addr, i_funct3          destination register, load size/sign
//   i_addr_ofs                   byte lane of the load inside the memory word
//   i_alu_result, i_pc_plus4,
//   i_imm                        candidate results
//   i_rsp_valid, i_rsp_data      data-memory read response
//   o_rf_we/o_rf_waddr/o_rf_wdata  registered register-file write port
//   o_retire, o_trap             one-cycle retire / load-fault pulses
//   o_retire_count               wrapping retired-instruction counter
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter  int XLEN  = 32,
  parameter  int CNT_W = 32,
  localparam int OFS_W = $clog2(XLEN / 8)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic [1:0]       i_wb_sel,
  input  logic [4:0]       i_rd_addr,
  input  logic [2:0]       i_funct3,
  input  logic [OFS_W-1:0] i_addr_ofs,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_rsp_valid,
  input  logic [XLEN-1:0]  i_rsp_data,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_waddr,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_retire,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_retire_count
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_t            state_q;

  // Hold register: the instruction accepted on the last transfer. Only loads
  // need it, since they complete several cycles after the MEM stage moved on.
  logic              hold_reg_write_q;
  logic              hold_bad_q;
  logic [1:0]        hold_wb_sel_q;
  logic [4:0]        hold_rd_q;
  logic [2:0]        hold_funct3_q;
  logic [OFS_W-1:0]  hold_ofs_q;
  logic [XLEN-1:0]   hold_alu_q;
  logic [XLEN-1:0]   hold_pc4_q;
  logic [XLEN-1:0]   hold_imm_q;

  logic              rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic              retire_q;
  logic              trap_q;
  logic [CNT_W-1:0]  count_q;

  logic [XLEN-1:0]   sel_in;
  logic [XLEN-1:0]   sel_hold;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_data;
  logic              bad_load_in;
  logic              misaligned_in;
  logic              illegal_in;
  logic [CNT_W-1:0]  count_d;

  function automatic logic [XLEN-1:0] pick_src(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] imm
  );
    case (sel)
      WB_ALU:  return alu;
      WB_MEM:  return mem;
      WB_PC4:  return pc4;
      default: return imm;
    endcase
  endfunction

  assign o_ready = (state_q == IDLE);

  // Non-loads select straight from the live inputs. Loads select from the
  // held copy, with the "mem" source replaced by the extracted load data.
  assign sel_in   = pick_src(i_wb_sel, i_alu_result, i_rsp_data, i_pc_plus4, i_imm);
  assign sel_hold = pick_src(hold_wb_sel_q, hold_alu_q, ld_data, hold_pc4_q, hold_imm_q);

  // Byte lane i_addr_ofs moved down to bit 0. The size casts below extend
  // signed operands with their MSB and unsigned operands with zeros.
  assign shifted = i_rsp_data >> {hold_ofs_q, 3'b000};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    ld_data = '0;
    case (hold_funct3_q)
      3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
      3'b100:  ld_data = XLEN'(shifted[7:0]);
      3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
      3'b101:  ld_data = XLEN'(shifted[15:0]);
      3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
      3'b110:  ld_data = XLEN'(shifted[31:0]);
      3'b011:  ld_data = shifted;
      default: ld_data = '0;
    endcase
  end

  // The fault is classified at accept time so WAIT_RSP only needs one flag.
  assign illegal_in = (i_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((i_funct3 == 3'b110) || (i_funct3 == 3'b011)));

  always_comb begin
    misaligned_in = 1'b0;
    case (i_funct3[1:0])
      2'b01:   misaligned_in = i_addr_ofs[0];
      2'b10:   misaligned_in = (i_addr_ofs[1:0] != 2'b00);
      2'b11:   misaligned_in = (i_addr_ofs != '0);
      default: misaligned_in = 1'b0;
    endcase
  end

  assign bad_load_in = illegal_in | misaligned_in;

  // The counter wraps silently at 2^CNT_W.
  assign count_d = count_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q          <= IDLE;
      hold_reg_write_q <= 1'b0;
      hold_bad_q       <= 1'b0;
      hold_wb_sel_q    <= '0;
      hold_rd_q        <= '0;
      hold_funct3_q    <= '0;
      hold_ofs_q       <= '0;
      hold_alu_q       <= '0;
      hold_pc4_q       <= '0;
      hold_imm_q       <= '0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      retire_q         <= 1'b0;
      trap_q           <= 1'b0;
      count_q          <= '0;
    end else begin
      // Pulses default low. The write address and data hold their values.
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_valid) begin
            hold_reg_write_q <= i_reg_write;
            hold_bad_q       <= bad_load_in;
            hold_wb_sel_q    <= i_wb_sel;
            hold_rd_q        <= i_rd_addr;
            hold_funct3_q    <= i_funct3;
            hold_ofs_q       <= i_addr_ofs;
            hold_alu_q       <= i_alu_result;
            hold_pc4_q       <= i_pc_plus4;
            hold_imm_q       <= i_imm;
            if (i_mem_read) begin
              state_q <= WAIT_RSP;
            end else begin
              retire_q <= 1'b1;
              count_q  <= count_d;
              if (i_reg_write && (i_rd_addr != 5'd0)) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= i_rd_addr;
                rf_wdata_q <= sel_in;
              end
            end
          end
        end

        WAIT_RSP: begin
          if (i_rsp_valid) begin
            state_q <= IDLE;
            if (hold_bad_q) begin
              trap_q <= 1'b1;
            end else begin
              retire_q <= 1'b1;
              count_q  <= count_d;
              if (hold_reg_write_q && (hold_rd_q != 5'd0)) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= hold_rd_q;
                rf_wdata_q <= sel_hold;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rf_we        = rf_we_q;
  assign o_rf_waddr     = rf_waddr_q;
  assign o_rf_wdata     = rf_wdata_q;
  assign o_retire       = retire_q;
  assign o_trap         = trap_q;
  assign o_retire_count = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Two instances share one stimulus bus: dut_a (XLEN=32, CNT_W=4) and
// dut_b (XLEN=64, CNT_W=32). Each has its own i_valid, so only one is
// addressed at a time. Expected values come from a reference model that
// applies the load rules with plain arithmetic (shift, mask, extend).
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_a, valid_b;
  logic        reg_write, mem_read;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [2:0]  ofs;
  logic [63:0] alu, pc4, imm, rsp_data;
  logic        rsp_valid;

  logic        ready_a, we_a, retire_a, trap_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [3:0]  count_a;

  logic        ready_b, we_b, retire_b, trap_b;
  logic [4:0]  waddr_b;
  logic [63:0] wdata_b;
  logic [31:0] count_b;

  writeback_unit #(.XLEN(32), .CNT_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .o_ready(ready_a),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_wb_sel(wb_sel),
    .i_rd_addr(rd), .i_funct3(f3), .i_addr_ofs(ofs[1:0]),
    .i_alu_result(alu[31:0]), .i_pc_plus4(pc4[31:0]), .i_imm(imm[31:0]),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data[31:0]),
    .o_rf_we(we_a), .o_rf_waddr(waddr_a), .o_rf_wdata(wdata_a),
    .o_retire(retire_a), .o_trap(trap_a), .o_retire_count(count_a)
  );

  writeback_unit #(.XLEN(64), .CNT_W(32)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .o_ready(ready_b),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_wb_sel(wb_sel),
    .i_rd_addr(rd), .i_funct3(f3), .i_addr_ofs(ofs),
    .i_alu_result(alu), .i_pc_plus4(pc4), .i_imm(imm),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_rf_we(we_b), .o_rf_waddr(waddr_b), .o_rf_wdata(wdata_b),
    .o_retire(retire_b), .o_trap(trap_b), .o_retire_count(count_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [31:0] exp_cnt    [2];
  logic [4:0]  last_waddr [2];
  logic [63:0] last_wdata [2];
  logic [31:0] cnt_mask   [2];

  logic        exp_we, exp_retire, exp_trap;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;
  logic [31:0] exp_count;

  logic        obs_we, obs_retire, obs_trap, obs_ready;
  logic [4:0]  obs_waddr;
  logic [63:0] obs_wdata;
  logic [31:0] obs_count;
  int          obs_ready_low;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_cnt[i]    = '0;
      last_waddr[i] = '0;
      last_wdata[i] = '0;
    end
  endtask

  // Applies the current bus contents as one transaction to the model.
  task automatic predict(input bit which);
    logic [63:0] m, shifted, mask, v, src;
    logic [2:0]  o;
    int          size;
    bit          illegal, mis;
    m       = which ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    o       = which ? ofs : {1'b0, ofs[1:0]};
    size    = 1 << f3[1:0];
    illegal = (f3 == 3'b111) || (!which && (f3 == 3'b110 || f3 == 3'b011));
    mis     = (int'(o) % size) != 0;
    shifted = (rsp_data & m) >> (8 * int'(o));
    mask    = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    v       = shifted & mask;
    if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    case (wb_sel)
      2'd0:    src = alu;
      2'd1:    src = mem_read ? v : rsp_data;
      2'd2:    src = pc4;
      default: src = imm;
    endcase
    src        = src & m;
    exp_trap   = mem_read && (illegal || mis);
    exp_retire = !exp_trap;
    exp_we     = exp_retire && reg_write && (rd != 5'd0);
    if (exp_we) begin
      last_waddr[which] = rd;
      last_wdata[which] = src;
    end
    if (exp_retire) exp_cnt[which] = (exp_cnt[which] + 32'd1) & cnt_mask[which];
    exp_waddr = last_waddr[which];
    exp_wdata = last_wdata[which];
    exp_count = exp_cnt[which];
  endtask

  task automatic sample(input bit which);
    if (which) begin
      obs_we = we_b; obs_retire = retire_b; obs_trap = trap_b; obs_ready = ready_b;
      obs_waddr = waddr_b; obs_wdata = wdata_b; obs_count = count_b;
    end else begin
      obs_we = we_a; obs_retire = retire_a; obs_trap = trap_a; obs_ready = ready_a;
      obs_waddr = waddr_a; obs_wdata = {32'd0, wdata_a}; obs_count = {28'd0, count_a};
    end
  endtask

  // Drives one transaction. A load gets its response on the delay-th edge
  // after accept. The held fields are scrambled meanwhile, so the result can
  // only come from the unit's own copy.
  task automatic send(input bit which, input int delay);
    predict(which);
    if (which) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    obs_ready_low = 0;
    if (mem_read) begin
      alu = {$urandom, $urandom}; pc4 = {$urandom, $urandom}; imm = {$urandom, $urandom};
      f3 = 3'($urandom); ofs = 3'($urandom); wb_sel = 2'($urandom); rd = 5'($urandom);
      for (int k = 1; k <= delay; k++) begin
        if (!(which ? ready_b : ready_a)) obs_ready_low++;
        if (k == delay) rsp_valid = 1'b1;
        @(posedge clk); #1;
      end
      rsp_valid = 1'b0;
      rsp_data  = {$urandom, $urandom};
    end
    sample(which);
  endtask

  task automatic set_fields(input logic rw, input logic mr, input logic [1:0] ws,
                            input logic [4:0] r, input logic [2:0] fn, input logic [2:0] of);
    reg_write = rw; mem_read = mr; wb_sel = ws; rd = r; f3 = fn; ofs = of;
  endtask

  task automatic test_reset();
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_a); end
    checks++; if (we_a !== 1'b0 || retire_a !== 1'b0 || trap_a !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%b%b%b want=000", we_a, retire_a, trap_a); end
    checks++; if (waddr_a !== 5'd0 || wdata_a !== 32'd0) begin
      failures++; $display("FAIL reset_wport got=%h/%h want=0/0", waddr_a, wdata_a); end
    checks++; if (count_a !== 4'd0 || count_b !== 32'd0) begin
      failures++; $display("FAIL reset_count got=%h/%h want=0/0", count_a, count_b); end
    checks++; if (ready_b !== 1'b1 || we_b !== 1'b0 || wdata_b !== 64'd0) begin
      failures++; $display("FAIL reset_b got=%b%b %h want=10 0", ready_b, we_b, wdata_b); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      set_fields(1'b1, 1'b0, 2'd0, 5'(i + 1), 3'd0, 3'd0);
      alu = {32'd0, vals[i]};
      predict(0);
      valid_a = 1'b1;
      @(posedge clk); #1;
      checks++; if (we_a !== 1'b1 || waddr_a !== 5'(i + 1) || wdata_a !== vals[i]) begin
        failures++; $display("FAIL b2b_write%0d got=%b/%h/%h want=1/%h/%h", i, we_a, waddr_a, wdata_a, 5'(i + 1), vals[i]); end
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b want=1", i, ready_a); end
    end
    valid_a = 1'b0;
    checks++; if (count_a !== 4'd3) begin failures++; $display("FAIL b2b_count got=%0d want=3", count_a); end
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b0 || retire_a !== 1'b0) begin
      failures++; $display("FAIL b2b_pulse_end got=%b%b want=00", we_a, retire_a); end
  endtask

  task automatic test_load_sign();
    logic [31:0] c0;
    set_fields(1'b1, 1'b1, 2'd1, 5'd5, 3'b000, 3'd3);
    rsp_data = 64'h0000_0000_80FF_1234;
    c0 = {28'd0, count_a};
    send(0, 4);
    checks++; if (obs_ready_low != 4) begin failures++; $display("FAIL lb_ready_low got=%0d want=4", obs_ready_low); end
    checks++; if (obs_we !== 1'b1 || obs_waddr !== 5'd5 || obs_wdata !== 64'hFFFF_FF80) begin
      failures++; $display("FAIL lb_data got=%b/%h/%h want=1/05/ffffff80", obs_we, obs_waddr, obs_wdata); end
    checks++; if (obs_retire !== 1'b1 || obs_count !== ((c0 + 1) & 32'hF)) begin
      failures++; $display("FAIL lb_retire got=%b/%0d want=1/%0d", obs_retire, obs_count, (c0 + 1) & 32'hF); end
    set_fields(1'b1, 1'b1, 2'd1, 5'd6, 3'b100, 3'd3);
    rsp_data = 64'h0000_0000_80FF_1234;
    send(0, 4);
    checks++; if (obs_we !== 1'b1 || obs_wdata !== 64'h0000_0080) begin
      failures++; $display("FAIL lbu_data got=%b/%h want=1/00000080", obs_we, obs_wdata); end
    @(posedge clk); #1;
    checks++; if (we_a !== 1'b0 || ready_a !== 1'b1) begin
      failures++; $display("FAIL lbu_after got=%b%b want=01", we_a, ready_a); end
  endtask

  task automatic test_trap();
    logic [3:0] c0;
    c0 = count_a;
    set_fields(1'b1, 1'b1, 2'd1, 5'd9, 3'b001, 3'd1);
    rsp_data = {$urandom, $urandom};
    send(0, 2);
    checks++; if (obs_trap !== 1'b1 || obs_we !== 1'b0 || obs_retire !== 1'b0) begin
      failures++; $display("FAIL lh_trap got=t%b w%b r%b want=t1 w0 r0", obs_trap, obs_we, obs_retire); end
    checks++; if (obs_count !== {28'd0, c0} || obs_wdata !== 64'h0000_0080) begin
      failures++; $display("FAIL lh_hold got=%0d/%h want=%0d/00000080", obs_count, obs_wdata, c0); end
    set_fields(1'b1, 1'b1, 2'd1, 5'd9, 3'b010, 3'd2);
    send(0, 3);
    checks++; if (obs_trap !== 1'b1 || obs_we !== 1'b0 || obs_count !== {28'd0, c0}) begin
      failures++; $display("FAIL lw_trap got=t%b w%b c%0d want=t1 w0 c%0d", obs_trap, obs_we, obs_count, c0); end
    @(posedge clk); #1;
    checks++; if (trap_a !== 1'b0) begin failures++; $display("FAIL trap_pulse got=%b want=0", trap_a); end
  endtask

  task automatic test_jal_rd0();
    logic [3:0] c0;
    c0 = count_a;
    set_fields(1'b1, 1'b0, 2'd2, 5'd0, 3'd0, 3'd0);
    pc4 = 64'h104;
    send(0, 1);
    checks++; if (obs_we !== 1'b0 || obs_retire !== 1'b1) begin
      failures++; $display("FAIL jal_rd0 got=w%b r%b want=w0 r1", obs_we, obs_retire); end
    checks++; if (obs_count !== {28'd0, c0 + 4'd1} || obs_wdata !== 64'h0000_0080) begin
      failures++; $display("FAIL jal_count got=%0d/%h want=%0d/00000080", obs_count, obs_wdata, c0 + 4'd1); end
  endtask

  task automatic test_idle_rsp();
    logic [3:0] c0;
    c0 = count_a;
    rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    checks++; if (we_a !== 1'b0 || retire_a !== 1'b0 || count_a !== c0 || ready_a !== 1'b1) begin
      failures++; $display("FAIL idle_rsp got=w%b r%b c%0d rdy%b want=w0 r0 c%0d rdy1", we_a, retire_a, count_a, ready_a, c0); end
  endtask

  task automatic test_xlen64();
    set_fields(1'b1, 1'b1, 2'd1, 5'd7, 3'b011, 3'd0);
    rsp_data = 64'h8000_0000_0000_0001;
    send(1, 2);
    checks++; if (obs_we !== 1'b1 || obs_wdata !== 64'h8000_0000_0000_0001) begin
      failures++; $display("FAIL ld64 got=%b/%h want=1/8000000000000001", obs_we, obs_wdata); end
    set_fields(1'b1, 1'b1, 2'd1, 5'd8, 3'b110, 3'd4);
    rsp_data = 64'hFFFF_FFFE_1234_5678;
    send(1, 1);
    checks++; if (obs_we !== 1'b1 || obs_waddr !== 5'd8 || obs_wdata !== 64'h0000_0000_FFFF_FFFE) begin
      failures++; $display("FAIL lwu64 got=%b/%h/%h want=1/08/00000000fffffffe", obs_we, obs_waddr, obs_wdata); end
    set_fields(1'b1, 1'b1, 2'd1, 5'd8, 3'b010, 3'd4);
    rsp_data = 64'hFFFF_FFFE_1234_5678;
    send(1, 3);
    checks++; if (obs_wdata !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++; $display("FAIL lw64 got=%h want=fffffffffffffffe", obs_wdata); end
  endtask

  task automatic test_random();
    bit which;
    for (int n = 0; n < 80; n++) begin
      which     = 1'($urandom);
      reg_write = 1'($urandom);
      mem_read  = 1'($urandom);
      wb_sel    = 2'($urandom);
      if (!mem_read && wb_sel == 2'd1) wb_sel = 2'd3;
      rd  = 5'($urandom);
      f3  = 3'($urandom);
      ofs = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case (f3[1:0])
          2'b01:   ofs[0] = 1'b0;
          2'b10:   ofs[1:0] = 2'b00;
          2'b11:   ofs = 3'd0;
          default: ;
        endcase
      end
      alu = {$urandom, $urandom}; pc4 = {$urandom, $urandom};
      imm = {$urandom, $urandom}; rsp_data = {$urandom, $urandom};
      send(which, $urandom_range(1, 3));
      checks++; if (obs_we !== exp_we || obs_retire !== exp_retire || obs_trap !== exp_trap) begin
        failures++; $display("FAIL rand%0d_flags dut%0d got=w%b r%b t%b want=w%b r%b t%b",
                             n, which, obs_we, obs_retire, obs_trap, exp_we, exp_retire, exp_trap); end
      checks++; if (obs_waddr !== exp_waddr || obs_wdata !== exp_wdata) begin
        failures++; $display("FAIL rand%0d_wport dut%0d f3=%b got=%h/%h want=%h/%h",
                             n, which, f3, obs_waddr, obs_wdata, exp_waddr, exp_wdata); end
      checks++; if (obs_count !== exp_count) begin
        failures++; $display("FAIL rand%0d_count dut%0d got=%0d want=%0d", n, which, obs_count, exp_count); end
    end
  endtask

  task automatic test_reset_mid_load();
    set_fields(1'b1, 1'b1, 2'd1, 5'd4, 3'b010, 3'd0);
    rsp_data = 64'h0000_0000_DEAD_BEEF;
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL rml_wait got=%b want=0", ready_a); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (ready_a !== 1'b1 || we_a !== 1'b0 || count_a !== 4'd0 || wdata_a !== 32'd0) begin
      failures++; $display("FAIL rml_async got=rdy%b w%b c%0d d%h want=rdy1 w0 c0 d0", ready_a, we_a, count_a, wdata_a); end
    #10;
    rst = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    checks++; if (we_a !== 1'b0 || retire_a !== 1'b0 || count_a !== 4'd0 || ready_a !== 1'b1) begin
      failures++; $display("FAIL rml_after got=w%b r%b c%0d rdy%b want=w0 r0 c0 rdy1", we_a, retire_a, count_a, ready_a); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      set_fields(1'b1, 1'b0, 2'd0, 5'((i % 31) + 1), 3'd0, 3'd0);
      alu = {$urandom, $urandom};
      predict(0);
      valid_a = 1'b1;
      @(posedge clk); #1;
      if (i == 15) begin
        checks++; if (count_a !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d want=0", count_a); end
      end
    end
    valid_a = 1'b0;
    checks++; if (count_a !== 4'd1 || retire_a !== 1'b1) begin
      failures++; $display("FAIL wrap_count got=%0d r%b want=1 r1", count_a, retire_a); end
  endtask

  initial begin
    cnt_mask[0] = 32'h0000_000F;
    cnt_mask[1] = 32'hFFFF_FFFF;
    model_reset();
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; rsp_valid = 1'b0;
    set_fields(1'b0, 1'b0, 2'd0, 5'd0, 3'd0, 3'd0);
    alu = '0; pc4 = '0; imm = '0; rsp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_back_to_back();
    test_load_sign();
    test_trap();
    test_jal_rd0();
    test_idle_rsp();
    test_xlen64();
    test_random();
    test_reset_mid_load();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
